// File: rtl/aes_pkg.sv
// Shared AES helpers for the iterative core: FSM state type, round count
// per key size, S-box lookup, xtime, MixColumns on one column, ShiftRows,
// and word-level helpers used by the key expansion step.
package aes_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} aes_state_t;

  // FIPS-197 S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int unsigned nr(input int unsigned key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  // Byte 4*c+r sits at row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Block handshake for aes_iter_core.
//   in_valid/in_ready/data_in/key : plaintext + key acceptance
//   out_valid/out_ready/data_out  : ciphertext delivery
//   busy                          : core is not idle
// master = producer/consumer side, slave = the core.
interface aes_iter_core_if #(parameter int unsigned KEY_BITS = 128);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        data_in;
  logic [KEY_BITS-1:0] key;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        data_out;
  logic                busy;

  modport master (output in_valid, data_in, key, out_ready,
                  input  in_ready, out_valid, data_out, busy);
  modport slave  (input  in_valid, data_in, key, out_ready,
                  output in_ready, out_valid, data_out, busy);
endinterface

// File: rtl/aes_key_step.sv
// One step of on-the-fly AES key expansion (combinational).
//   win      : current key window (128: round key r-1; 256: {RK r-1, RK r})
//   rcon     : current round constant
//   odd_step : 256-bit only; selects RotWord+SubWord+Rcon vs SubWord only
//   next_win : window for the following round
module aes_key_step
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic [KEY_BITS-1:0] win,
  input  logic [7:0]          rcon,
  input  logic                odd_step,
  output logic [KEY_BITS-1:0] next_win
);

  if (KEY_BITS == 128) begin : g_k128
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    logic        unused_odd_step;
    assign unused_odd_step = odd_step;
    always_comb begin
      {w0, w1, w2, w3} = win;
      t  = sub_word(rot_word(w3)) ^ {rcon, 24'h0};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      next_win = {n0, n1, n2, n3};
    end
  end else begin : g_k256
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, t, n0, n1, n2, n3;
    always_comb begin
      {w0, w1, w2, w3, w4, w5, w6, w7} = win;
      t  = odd_step ? (sub_word(rot_word(w7)) ^ {rcon, 24'h0}) : sub_word(w7);
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      // The window slides forward by one 128-bit half.
      next_win = {w4, w5, w6, w7, n0, n1, n2, n3};
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core, one round per clock, key expanded on the fly.
//   clk, rst : clock, synchronous active-high reset
//   bus      : aes_iter_core_if slave (in/out handshake, data, key, busy)
// Acceptance to out_valid latency is NR+1 cycles; result is held in DONE
// until out_ready.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input logic             clk,
  input logic             rst,
  aes_iter_core_if.slave  bus
);

  localparam int unsigned NR   = nr(KEY_BITS);
  localparam logic [3:0]  NR_L = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $fatal(1, "aes_iter_core: KEY_BITS must be 128 or 256");
  end

  aes_state_t          state_q, state_d;
  logic [3:0]          round_q;
  logic [7:0]          rcon_q;
  logic [127:0]        st_q;
  logic [KEY_BITS-1:0] key_q, key_nxt;
  logic [127:0]        round_key, sr, mc, rnd_out;
  logic                accept, last_round, rcon_use, done;

  assign accept     = (state_q == ST_IDLE) && bus.in_valid;
  assign last_round = (round_q == NR_L);
  // 256-bit keys consume Rcon only on odd steps.
  assign rcon_use   = (KEY_BITS == 128) || round_q[0];
  assign done       = (state_q == ST_DONE);

  aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
    .win      (key_q),
    .rcon     (rcon_q),
    .odd_step (round_q[0]),
    .next_win (key_nxt)
  );

  // 128: round key r is derived this cycle; 256: it is already the low half.
  assign round_key = (KEY_BITS == 128) ? key_nxt[127:0] : key_q[127:0];

  always_comb begin
    sr = shift_rows(sub_bytes(st_q));
    mc = '0;
    for (int unsigned c = 0; c < 4; c++)
      mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
    rnd_out = (last_round ? sr : mc) ^ round_key;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.in_valid)  state_d = ST_ROUND;
      ST_ROUND: if (last_round)    state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= '0;
      rcon_q  <= 8'h01;
      st_q    <= '0;
      key_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          st_q    <= bus.data_in ^ bus.key[KEY_BITS-1 -: 128];
          key_q   <= bus.key;
          round_q <= 4'd1;
          rcon_q  <= 8'h01;
        end
        ST_ROUND: begin
          st_q    <= rnd_out;
          key_q   <= key_nxt;
          round_q <= round_q + 4'd1;
          if (rcon_use) rcon_q <= xtime(rcon_q);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = done;
  assign bus.data_out  = done ? st_q : '0;

endmodule

// File: tb/tb_aes_iter_core.sv
module tb_aes_iter_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  aes_iter_core_if #(.KEY_BITS(128)) b128 ();
  aes_iter_core_if #(.KEY_BITS(256)) b256 ();
  aes_iter_core #(.KEY_BITS(128)) dut128 (.clk(clk), .rst(rst), .bus(b128.slave));
  aes_iter_core #(.KEY_BITS(256)) dut256 (.clk(clk), .rst(rst), .bus(b256.slave));

  logic         iv[2], ordy[2], irdy[2], ovld[2], bsy[2], rdy_rand[2];
  logic [127:0] pt_v[2], dout[2];
  logic [255:0] key_v[2];

  assign b128.in_valid  = iv[0];
  assign b128.data_in   = pt_v[0];
  assign b128.key       = key_v[0][255:128];
  assign b128.out_ready = ordy[0];
  assign irdy[0] = b128.in_ready;
  assign ovld[0] = b128.out_valid;
  assign bsy[0]  = b128.busy;
  assign dout[0] = b128.data_out;
  assign b256.in_valid  = iv[1];
  assign b256.data_in   = pt_v[1];
  assign b256.key       = key_v[1];
  assign b256.out_ready = ordy[1];
  assign irdy[1] = b256.in_ready;
  assign ovld[1] = b256.out_valid;
  assign bsy[1]  = b256.busy;
  assign dout[1] = b256.data_out;

  typedef struct {
    logic [127:0] exp;
    int unsigned  acc;
  } sb_item_t;
  sb_item_t sbq[2][$];

  int unsigned  checks = 0, errors = 0;
  bit           mon_on = 1'b0;
  logic         prev_v[2];
  logic [127:0] held[2];
  logic [7:0]   rsb[256];

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic void build_sbox();
    logic [7:0]  inv;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      d = {inv, inv};
      rsb[x] = inv ^ d[14 -: 8] ^ d[13 -: 8] ^ d[12 -: 8] ^ d[11 -: 8] ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {rsb[t[31:24]], rsb[t[23:16]], rsb[t[15:8]], rsb[t[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] k,
                                           input int kb);
    int          nk, nrr;
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  s[4][4], u[4][4];
    logic [127:0] o;
    nk = kb / 32; nrr = nk + 6; rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nrr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= nrr; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) u[r][c] = rsb[s[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < nrr)
            s[r][c] = gmul(8'h02, u[r][c]) ^ gmul(8'h03, u[(r+1)%4][c]) ^
                      u[(r+2)%4][c] ^ u[(r+3)%4][c];
          else
            s[r][c] = u[r][c];
          s[r][c] ^= w[4*rnd + c][31 - 8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127 - 8*(4*c + r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] exp_of(input int d, input logic [127:0] p, input logic [255:0] k);
    return (d == 1) ? aes_ref(p, k, 256) : aes_ref(p, {k[255:128], 128'h0}, 128);
  endfunction

  // ---------------- monitor ----------------
  function automatic void mon_step(input int d);
    bit          exp_busy;
    int unsigned nrr;
    nrr = (d == 1) ? 14 : 10;
    exp_busy = (sbq[d].size() > 0) && (cyc > sbq[d][0].acc);
    chk($sformatf("dut%0d busy", d), bsy[d], exp_busy);
    chk($sformatf("dut%0d in_ready", d), irdy[d], !exp_busy);
    if (!ovld[d]) begin
      chk($sformatf("dut%0d data_out idle zero", d), dout[d], '0);
    end else if (sbq[d].size() == 0) begin
      chk($sformatf("dut%0d unexpected out_valid", d), ovld[d], 1'b0);
    end else begin
      if (!prev_v[d]) begin
        chk($sformatf("dut%0d latency", d), cyc - sbq[d][0].acc, nrr + 1);
        held[d] = dout[d];
      end else begin
        chk($sformatf("dut%0d data_out stable", d), dout[d], held[d]);
      end
      if (ordy[d]) begin
        chk($sformatf("dut%0d ciphertext", d), dout[d], sbq[d][0].exp);
        void'(sbq[d].pop_front());
      end
    end
    prev_v[d] = ovld[d];
  endfunction

  always @(negedge clk)
    if (mon_on && !rst)
      for (int d = 0; d < 2; d++) mon_step(d);

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      if (rdy_rand[d]) ordy[d] = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input int d, input logic [127:0] p, input logic [255:0] k,
                      input logic [127:0] e, output int unsigned acc);
    int n;
    n = 0;
    pt_v[d] = p; key_v[d] = k; iv[d] = 1'b1;
    while (!irdy[d] && n < 100) begin tick(); n++; end
    acc = cyc;
    if (!irdy[d]) chk($sformatf("dut%0d accept timeout", d), irdy[d], 1'b1);
    else sbq[d].push_back('{exp: e, acc: cyc});
    tick();
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (sbq[d].size() != 0 && n < 300) begin tick(); n++; end
    if (sbq[d].size() != 0) begin
      chk($sformatf("dut%0d completion timeout", d), sbq[d].size(), 0);
      sbq[d].delete();
    end
  endtask

  localparam logic [255:0] K36 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K37 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K38 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P36 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P37 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C37 = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned  a1, a2;
    int           n;
    logic [127:0] p, p2;
    logic [255:0] k, k2;
    build_sbox();
    for (int d = 0; d < 2; d++) begin
      prev_v[d] = 1'b0; rdy_rand[d] = 1'b0; ordy[d] = 1'b1;
      iv[d] = 1'b1; pt_v[d] = r128(); key_v[d] = {r128(), r128()};
    end
    // in_valid held high during reset must not be accepted
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0; iv[0] = 1'b0; iv[1] = 1'b0;
    mon_on = 1'b1;
    tick();

    // known-answer vectors
    send(0, P36, K36, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, a1); iv[0] = 1'b0; wait_done(0);
    send(0, P37, K37, C37, a1); iv[0] = 1'b0; wait_done(0);
    send(1, P36, K38, 128'h8ea2b7ca516745bfeafc49904b496089, a1); iv[1] = 1'b0; wait_done(1);

    // output stall: 20 cycles of out_ready low with in_valid noise
    ordy[0] = 1'b0;
    p = r128(); k = {r128(), r128()};
    send(0, p, k, exp_of(0, p, k), a1); iv[0] = 1'b0;
    n = 0;
    while (!ovld[0] && n < 50) begin tick(); n++; end
    chk("dut0 out_valid during stall", ovld[0], 1'b1);
    repeat (20) begin
      iv[0] = 1'b1; pt_v[0] = r128(); key_v[0] = {r128(), r128()};
      tick();
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    tick();
    chk("dut0 in_ready after release", irdy[0], 1'b1);

    // reset in round 5 discards the block; next block is unaffected
    send(0, P37, K37, C37, a1); iv[0] = 1'b0;
    while (cyc < a1 + 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sbq[0].delete(); prev_v[0] = 1'b0; prev_v[1] = 1'b0;
    repeat (20) tick();
    send(0, P37, K37, C37, a1); iv[0] = 1'b0; wait_done(0);

    // back-to-back with in_valid held high
    for (int d = 0; d < 2; d++) begin
      p = r128(); k = {r128(), r128()}; p2 = r128(); k2 = {r128(), r128()};
      send(d, p, k, exp_of(d, p, k), a1);
      send(d, p2, k2, exp_of(d, p2, k2), a2);
      iv[d] = 1'b0;
      chk($sformatf("dut%0d back-to-back spacing", d), a2 - a1, (d == 1) ? 16 : 12);
      wait_done(d);
    end

    // random blocks, random out_ready, inputs scrambled after acceptance
    for (int d = 0; d < 2; d++) begin
      rdy_rand[d] = 1'b1;
      repeat (12) begin
        p = r128(); k = {r128(), r128()};
        send(d, p, k, exp_of(d, p, k), a1);
        iv[d] = 1'b0;
        repeat ($urandom_range(1, 4)) begin
          pt_v[d] = r128(); key_v[d] = {r128(), r128()};
          tick();
        end
      end
      wait_done(d);
      rdy_rand[d] = 1'b0;
      tick();
      ordy[d] = 1'b1;
      wait_done(d);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 The block SHALL have parameter KEY_BITS, default 128, selecting the AES key size; only 128 and 256 are legal, and any other value SHALL fail elaboration.
REQ-002 The block SHALL derive constant NR = 10 for KEY_BITS=128 and NR = 14 for KEY_BITS=256.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  data_in and key are valid this cycle.
REQ-006 in_ready  output  1  the block accepts a block this cycle.
REQ-007 data_in  input  128  plaintext block, byte 0 in bits [127:120].
REQ-008 key  input  KEY_BITS  cipher key, byte 0 in the MSBs.
REQ-009 out_valid  output  1  data_out holds a completed ciphertext.
REQ-010 out_ready  input  1  the consumer takes data_out this cycle.
REQ-011 data_out  output  128  ciphertext block, same byte order as data_in.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement FIPS-197 AES encryption iteratively at one round per clock, with on-the-fly key expansion; it SHALL NOT store a full key schedule.
REQ-014 The FSM SHALL have states IDLE, ROUND and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; an acceptance (handshake) occurs when in_valid && in_ready.
REQ-016 On acceptance in cycle T, the block SHALL register data_in^key[KEY_BITS-1:KEY_BITS-128] as the state and register the key, set the round counter to 1, and enter ROUND.
REQ-017 In ROUND, each cycle SHALL apply SubBytes, ShiftRows, MixColumns (omitted when round == NR) and AddRoundKey with round key r; the counter SHALL increment, and the FSM SHALL enter DONE after round NR.
REQ-018 out_valid SHALL rise in cycle T+NR+1, so acceptance-to-out_valid latency is exactly NR+1 cycles (11 for 128-bit keys, 15 for 256-bit keys).
REQ-019 In DONE, data_out and out_valid SHALL hold stable until out_valid && out_ready, after which the FSM SHALL return to IDLE on the next edge.
REQ-020 in_ready SHALL stay 0 in the cycle where DONE completes; back-to-back throughput is one block per NR+2 cycles.
REQ-021 data_out SHALL be 0 whenever out_valid is 0.
REQ-022 For KEY_BITS=128, round key r SHALL be computed each cycle from round key r-1 using RotWord, SubWord and Rcon.
REQ-023 For KEY_BITS=256, the 256-bit key window SHALL advance by one 128-bit half per round.
REQ-024 For KEY_BITS=256, odd-step words SHALL use RotWord, SubWord and Rcon, and even-step words SHALL use SubWord only.
REQ-025 Rcon SHALL be held in an 8-bit register starting at 0x01 and updated by xtime on each Rcon use; it SHALL be reinitialised on every acceptance.
REQ-026 Changes on data_in and key after acceptance SHALL have no effect on the block in progress.
REQ-027 in_valid asserted while busy SHALL be ignored, with no acceptance and no state change.

Reset
REQ-028 While rst is high at a clock edge, the FSM SHALL go to IDLE.
REQ-029 While rst is high at a clock edge, out_valid, busy and data_out SHALL go to 0, the round counter to 0, and Rcon to 0x01; in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-030 Reset asserted mid-ROUND or in DONE SHALL discard the block with no out_valid pulse, and the next acceptance SHALL produce correct results.
REQ-031 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-032 Shared package aes_pkg SHALL hold: the S-box as a constant function, xtime, a MixColumns column function, a ShiftRows function, and an nr(key_bits) function.
REQ-033 The FSM state enumeration SHALL be defined in aes_pkg.
REQ-034 Key expansion SHALL live in one sub-module, aes_key_step (parameter KEY_BITS; inputs: current key window, Rcon, step parity; output: next window), which is purely combinational.
REQ-035 All state registers SHALL live in aes_iter_core.

Verification
REQ-036 KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 11 cycles after acceptance.
REQ-037 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-038 KEY_BITS=256, key 000102...1e1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089, with out_valid 15 cycles after acceptance.
REQ-039 out_ready held 0 for 20 cycles after out_valid -> data_out stable, in_ready 0, in_valid ignored; an out_ready pulse -> IDLE and in_ready 1 on the next cycle.
REQ-040 rst pulsed at round 5 -> no out_valid; the vector from REQ-037 applied next -> correct ciphertext with nominal latency.
REQ-041 Two blocks offered back-to-back with in_valid held high and out_ready held high -> two correct ciphertexts, with acceptances NR+2 cycles apart.
